// File: rtl/bcd_step_counter.sv
// bcd_step_counter: single-digit BCD up/down counter advanced by rising
// edges of a raw STEP level. Provides range-checked synchronous load, a
// one-cycle wrap pulse (TC) for cascading digits and a sticky ERR flag for
// rejected loads. Q stays within 0..MAX at all times.
//
// Build option: define BCD_STEP_SYNC_EN to pass STEP through a two-flop
// synchronizer (reset to 1) before edge detection. This adds 2 cycles of
// count latency. Leave it undefined when STEP is already synchronous to CLK.
module bcd_step_counter #(
  parameter int unsigned MAX = 9   // highest count value, legal 1..9
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       STEP,
  input  logic       UP,
  input  logic       LD,
  input  logic [3:0] D,
  input  logic       CLR_ERR,
  output logic [3:0] Q,
  output logic       TC,
  output logic       ERR
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  logic       step_s;
  logic       step_prev_reg;
  logic       step_edge;
  logic [3:0] q_reg,   q_next;
  logic       tc_reg,  tc_next;
  logic       err_reg, err_next;

`ifdef BCD_STEP_SYNC_EN
  localparam int SYNC_STAGES = 2;

  // Synchronizer chain resets to 1 so a STEP held high across reset
  // release looks like a steady high level rather than a fresh edge.
  logic sync_reg [SYNC_STAGES];

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First stage samples the raw asynchronous STEP level.
        always_ff @(posedge CLK or posedge RST) begin
          if (RST) sync_reg[gi] <= 1'b1;
          else     sync_reg[gi] <= STEP;
        end
      end else begin : g_rest
        // Later stages shift the sampled level down the chain.
        always_ff @(posedge CLK or posedge RST) begin
          if (RST) sync_reg[gi] <= 1'b1;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign step_s = sync_reg[SYNC_STAGES-1];
`else
  assign step_s = STEP;
`endif

  // A step edge is a low-to-high change between consecutive samples.
  assign step_edge = step_s & ~step_prev_reg;

  // Track the previous STEP sample every cycle, regardless of EN or LD;
  // resetting to 1 suppresses a count when STEP is high at reset release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) step_prev_reg <= 1'b1;
    else     step_prev_reg <= step_s;
  end

  // Next-state for count, wrap pulse and error flag, load has priority.
  always_comb begin
    q_next   = q_reg;
    tc_next  = 1'b0;
    err_next = err_reg;

    // Clear first so that a simultaneous illegal load re-sets the flag.
    if (CLR_ERR) err_next = 1'b0;

    if (LD) begin
      // Any step edge in a load cycle is dropped, not deferred.
      if (D <= MAX_V) q_next   = D;
      else            err_next = 1'b1;
    end else if (step_edge && EN) begin
      if (UP) begin
        if (q_reg >= MAX_V) begin
          q_next  = 4'd0;
          tc_next = 1'b1;
        end else begin
          q_next  = q_reg + 4'd1;
        end
      end else begin
        if (q_reg == 4'd0) begin
          q_next  = MAX_V;
          tc_next = 1'b1;
        end else begin
          q_next  = q_reg - 4'd1;
        end
      end
    end
  end

  // Counter state registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_reg   <= 4'd0;
      tc_reg  <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      tc_reg  <= tc_next;
      err_reg <= err_next;
    end
  end

  assign Q   = q_reg;
  assign TC  = tc_reg;
  assign ERR = err_reg;

endmodule

// File: doc/bcd_step_counter.md
# bcd_step_counter

Single-digit BCD up/down counter that advances on rising edges of a raw step input and drives the 4-bit BCD value consumed by the 1-of-10 one-hot decoder stage (its `Q` connects directly to the decoder's B input). The counter keeps `Q` in the legal range 0..MAX at all times, so the decoder's out-of-range flag never asserts in normal use. The block also provides synchronous parallel load with range checking, a wrap pulse for cascading digits, and a sticky error flag for rejected loads.

## Interface
Parameters:
- MAX, default 9: highest count value. Legal range 1..9. The count wraps MAX→0 counting up and 0→MAX counting down.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- EN  input  1  count enable. Step edges are ignored while low.
- STEP  input  1  raw step level. Counting occurs on its rising edge.
- UP  input  1  direction: 1 = increment, 0 = decrement. Sampled in the same cycle the step edge is detected.
- LD  input  1  synchronous load strobe.
- D  input  4  load value.
- CLR_ERR  input  1  synchronous clear of ERR.
- Q  output  4  current BCD count, 0..MAX.
- TC  output  1  one-cycle wrap pulse.
- ERR  output  1  sticky illegal-load flag.

## Operation
- Internal state: `Q` register, `step_prev` register (previous sampled STEP), and the ERR flag.
- Edge detect: `step_edge = STEP_s & ~step_prev`. `STEP_s` is STEP, or the synchronized STEP when the sync option is compiled in. `step_prev <= STEP_s` every cycle, independent of EN and LD.
- Per-cycle priority, highest first:
  1. LD=1 with D ≤ MAX: `Q <= D`, TC=0.
  2. LD=1 with D > MAX: Q unchanged, ERR set, TC=0.
  3. step_edge & EN, UP=1: if Q = MAX then Q <= 0 and TC=1, else Q <= Q+1.
  4. step_edge & EN, UP=0: if Q = 0 then Q <= MAX and TC=1, else Q <= Q−1.
  5. Otherwise: hold, TC=0.
- A step edge that coincides with LD is discarded, not deferred.
- ERR is set by an illegal load and cleared by CLR_ERR. If both happen in the same cycle, set wins and ERR stays 1. ERR does not affect counting.
- Arithmetic is 4-bit unsigned. Q never takes a value above MAX, including during load and wrap.
- Reset mid-operation: all state returns to reset values immediately, regardless of CLK. A pending edge is lost.

## Timing
- Reset values: Q=0, TC=0, ERR=0, step_prev=1. Because step_prev resets to 1, a STEP held high through reset release produces no count.
- Count latency, sync option off: Q updates at the first CLK edge at which STEP is sampled 1 after being sampled 0 at the previous edge. TC is registered and asserts in the same cycle that Q shows the wrapped value.
- Count latency, sync option on: add 2 cycles.
- Load latency: Q = D, or ERR = 1 for an illegal value, one edge after LD is sampled.
- Minimum STEP high and low times: 1 CLK period each, or 3 periods with the sync option. Shorter pulses may be missed.
- Holding STEP high counts exactly once.
- TC is never asserted on two consecutive cycles unless two edges are detected on consecutive cycles. That pattern is impossible without sync, because an edge requires STEP to be sampled low at the preceding edge.

## Configuration
- Macro: `BCD_STEP_SYNC_EN`.
- Defined: STEP passes through a two-flop synchronizer, reset to 1, before edge detection. This suits asynchronous or mechanical sources and adds 2 cycles of latency. UP, LD, D, EN and CLR_ERR are not synchronized and must be synchronous to CLK.
- Undefined: STEP feeds the edge detector directly. The source must be synchronous to CLK.

## Test plan
- Reset/hold: assert RST with STEP=1, then release with STEP held at 1 → Q=0, TC=0, ERR=0, and no count occurs.
- Up wrap: MAX=9, EN=1, UP=1, 10 clean STEP pulses starting from Q=0 → Q steps 1..9 then 0. TC=1 for exactly one cycle at the 9→0 transition.
- Down wrap with custom MAX: MAX=5, UP=0, one pulse from Q=0 → Q=5, TC=1. The next pulse → Q=4, TC=0.
- Load: LD with D=7 → Q=7, ERR=0. Then LD with D=12 → Q stays 7, ERR=1. Then CLR_ERR together with LD D=10 → ERR remains 1. Then CLR_ERR alone → ERR=0.
- Collisions/enable: LD D=3 in the same cycle as a step edge → Q=3, and the step is discarded. A STEP pulse with EN=0 → Q unchanged. RST asserted mid-count at Q=6 → Q=0 asynchronously, before the next CLK edge.
- Sync build (`BCD_STEP_SYNC_EN` defined): a STEP rising edge → Q changes 2 cycles later than in the unsynced build. A 1-cycle STEP glitch may or may not count, but Q always stays ≤ MAX.
